rr_arbiter_8: RTL and testbench
===============================

// Module: rr_arbiter_8
// PURPOSE
//  Round-robin arbiter sharing one resource among 8 requesters; issues a one-hot grant plus 3-bit index.
//  Grant is held until the owner drops its request or the resource signals release; then one dead cycle.
//  Sits in front of any 8-way shared unit whose select is driven by a 3-bit index / 8-bit one-hot pair.
// PARAMETERS
//  N_REQ     8   number of requesters (fixed; logic sized for 8)
//  IDX_W     3   width of grant index (clog2 N_REQ)
//  MAX_HOLD  15  max cycles a grant may be held (used only with ARB_TIMEOUT_EN); 4-bit counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  req_i      in   8      per-requester request level; held high while wanting/using resource
//  rel_i      in   1      resource release pulse; ends current grant
//  gnt_o      out  8      one-hot grant; all-zero when no grant
//  gnt_idx_o  out  3      binary index of granted requester; valid only when gnt_vld_o=1
//  gnt_vld_o  out  1      a grant is active
//  timeout_o  out  1      1-cycle pulse when grant forcibly ended (ARB_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, gnt_o=0, gnt_idx_o=0, gnt_vld_o=0, timeout_o=0, ptr=0, hold_cnt=0.
//  - All outputs registered. gnt_o == (gnt_vld_o ? 1<<gnt_idx_o : 0) at all times.
//  - States: IDLE, BUSY, GAP.
//    IDLE: if |req_i -> pick winner, BUSY next cycle. Else stay.
//    BUSY: exit to GAP when req_i[gnt_idx_o]==0, or rel_i==1, or (timeout) hold_cnt==MAX_HOLD.
//    GAP : gnt_vld_o=0 for exactly one cycle; if |req_i -> pick winner, BUSY next; else IDLE.
//  - Pick: first set bit of req_i scanning ptr, ptr+1, ... ptr+7 (mod 8). On grant, ptr <= winner+1 (mod 8, 7->0).
//  - Latency: req rises in cycle N (state IDLE) -> gnt_vld_o=1 in N+1. Release in cycle M -> gnt_vld_o=0 in M+1 (GAP),
//    next grant visible M+2 at earliest. Back-to-back grants to different requesters therefore 1 cycle apart.
//  - Requests of non-owners while BUSY are ignored (no preemption); they are not latched, must stay high.
//  - Simultaneous rel_i and owner req drop: single release, single GAP.
//  - rel_i while IDLE/GAP: ignored.
//  - Sole requester re-requests after GAP: re-granted (wrap of ptr back onto it is legal).
//  - Reset mid-grant: grant drops asynchronously; ptr returns to 0 (fairness history lost by design).
// CONFIGURATION
//  ARB_TIMEOUT_EN defined: hold_cnt counts cycles in BUSY from 0 at grant; reaching MAX_HOLD forces exit to GAP,
//    timeout_o pulses 1 in the GAP cycle; ptr already advanced so owner loses priority.
//  ARB_TIMEOUT_EN undefined: no counter, grant held indefinitely, timeout_o constant 0.
// STRUCTURE
//  Shared package: state encoding constants (IDLE=2'd0, BUSY=2'd1, GAP=2'd2), N_REQ, IDX_W, MAX_HOLD default.
//  Sub-module rr_pick_8 (combinational): inputs req[7:0], ptr[2:0]; outputs any, win_idx[2:0]
//    (rotate by ptr, priority-encode, un-rotate). Top holds FSM, ptr, hold_cnt, output regs.
// TESTING
//  1 reset: rst_n=0 with req_i=8'hFF -> all outputs 0; release rst_n, next edge gnt_o=8'h01, gnt_idx_o=0.
//  2 rotation: req_i=8'hFF held, rel_i pulsed each BUSY cycle -> idx sequence 0,1,2..7,0 with one GAP between each.
//  3 skip: ptr=2, req_i=8'b1000_0010 -> grant idx 7; after release grant idx 1 (wrap), then idx 7 again.
//  4 owner drop: grant idx 4, drop req_i[4] in cycle M -> gnt_vld_o=0 at M+1, req_i[5] granted at M+2.
//  5 timeout (ARB_TIMEOUT_EN, MAX_HOLD=15): req_i=8'h03 held, no rel_i -> idx0 ends after 16 BUSY cycles,
//    timeout_o=1 one cycle, idx1 granted; without macro idx0 held for 1000 cycles, timeout_o=0.
//  6 async reset mid-grant: rst_n low between edges while BUSY -> gnt_o=0 immediately, ptr=0 after release.

Source files
------------

// File: rtl/rr_arbiter_8_pkg.sv
// Shared definitions for the 8-way round-robin arbiter: sizes, FSM encoding, hold limit.
package rr_arbiter_8_pkg;

  localparam int unsigned N_REQ        = 8;
  localparam int unsigned IDX_W        = 3;
  localparam int unsigned MAX_HOLD_DEF = 15;
  localparam int unsigned HOLD_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    GAP  = 2'd2
  } arb_state_e;

  function automatic logic [N_REQ-1:0] idx2onehot(input logic [IDX_W-1:0] idx);
    idx2onehot      = '0;
    idx2onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_arbiter_8_pick.sv
// Combinational round-robin pick: first set request bit at or after ptr, wrapping modulo 8.
module rr_pick_8
  import rr_arbiter_8_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic             any,
  output logic [IDX_W-1:0] win_idx
);

  logic [N_REQ-1:0] rot;
  logic [IDX_W-1:0] off;

  always_comb begin
    // rot[k] corresponds to requester (ptr + k) mod 8
    rot = N_REQ'({req, req} >> ptr);
    off = '0;
    for (int unsigned i = N_REQ; i > 0; i--) begin
      if (rot[i-1]) off = IDX_W'(i - 1);
    end
    any     = |req;
    win_idx = off + ptr;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// 8-way round-robin arbiter with hold-until-release grant and one dead cycle between grants.
// Optional forced grant expiry after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module rr_arbiter_8
  import rr_arbiter_8_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             rel_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_vld_o,
  output logic             timeout_o
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_vld_q, gnt_vld_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic             owner_drop;
  logic             timeout_hit;
  logic             busy_exit;
  logic             load;

  rr_pick_8 u_pick (
    .req     (req_i),
    .ptr     (ptr_q),
    .any     (pick_any),
    .win_idx (pick_idx)
  );

  assign owner_drop = ~req_i[gnt_idx_q];
  assign busy_exit  = owner_drop | rel_i | timeout_hit;
  assign load       = (state_q != BUSY) && pick_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      gnt_vld_q <= 1'b0;
      ptr_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      gnt_vld_q <= gnt_vld_d;
      ptr_q     <= ptr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pick_any) state_d = BUSY;
      BUSY:    if (busy_exit) state_d = GAP;
      GAP:     state_d = pick_any ? BUSY : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_vld_d = gnt_vld_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    if (load) begin
      gnt_vld_d = 1'b1;
      gnt_idx_d = pick_idx;
      ptr_d     = pick_idx + IDX_W'(1);
    end else if (state_q != BUSY || busy_exit) begin
      gnt_vld_d = 1'b0;
    end
    gnt_d = gnt_vld_d ? idx2onehot(gnt_idx_d) : '0;
  end

`ifdef ARB_TIMEOUT_EN
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic              timeout_q, timeout_d;

  assign timeout_hit = (state_q == BUSY) && (hold_cnt_q == HOLD_W'(MAX_HOLD_DEF));

  always_comb begin
    hold_cnt_d = hold_cnt_q;
    if (load) hold_cnt_d = '0;
    else if (state_q == BUSY && !busy_exit) hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    // Only flag expiry when nothing else would have ended the grant this cycle
    timeout_d = timeout_hit && !owner_drop && !rel_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      hold_cnt_q <= hold_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_hit = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = gnt_idx_q;
  assign gnt_vld_o = gnt_vld_q;

endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed self-checking bench for rr_arbiter_8; inputs driven and outputs sampled on the falling edge.
module tb_rr_arbiter_8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_i = 8'h00;
  logic       rel_i = 1'b0;
  logic [7:0] gnt_o;
  logic [2:0] gnt_idx_o;
  logic       gnt_vld_o;
  logic       timeout_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rr_arbiter_8 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_i),
    .rel_i     (rel_i),
    .gnt_o     (gnt_o),
    .gnt_idx_o (gnt_idx_o),
    .gnt_vld_o (gnt_vld_o),
    .timeout_o (timeout_o)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req_i = 8'h00; rel_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_i = 8'hFF; rel_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (gnt_o !== 8'h00) begin errors++; $display("FAIL reset_gnt got=%h exp=00", gnt_o); end
    checks++; if (gnt_idx_o !== 3'd0) begin errors++; $display("FAIL reset_idx got=%0d exp=0", gnt_idx_o); end
    checks++; if (gnt_vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld got=%b exp=0", gnt_vld_o); end
    checks++; if (timeout_o !== 1'b0) begin errors++; $display("FAIL reset_timeout got=%b exp=0", timeout_o); end
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (gnt_o !== 8'h01) begin errors++; $display("FAIL reset_first_gnt got=%h exp=01", gnt_o); end
    checks++; if (gnt_idx_o !== 3'd0) begin errors++; $display("FAIL reset_first_idx got=%0d exp=0", gnt_idx_o); end
    checks++; if (gnt_vld_o !== 1'b1) begin errors++; $display("FAIL reset_first_vld got=%b exp=1", gnt_vld_o); end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx;
    logic [7:0] exp_gnt;
    do_reset();
    req_i = 8'hFF;
    for (int k = 0; k < 9; k++) begin
      exp_idx = 3'(k);
      exp_gnt = 8'h01 << exp_idx;
      @(negedge clk);
      checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== exp_idx || gnt_o !== exp_gnt) begin
        errors++; $display("FAIL rotation_grant k=%0d got vld=%b idx=%0d gnt=%h exp vld=1 idx=%0d gnt=%h",
                           k, gnt_vld_o, gnt_idx_o, gnt_o, exp_idx, exp_gnt);
      end
      rel_i = 1'b1;
      @(negedge clk);
      checks++; if (gnt_vld_o !== 1'b0 || gnt_o !== 8'h00) begin
        errors++; $display("FAIL rotation_gap k=%0d got vld=%b gnt=%h exp vld=0 gnt=00", k, gnt_vld_o, gnt_o);
      end
      rel_i = 1'b0;
    end
  endtask

  task automatic test_skip();
    logic [2:0] exp_seq [4];
    exp_seq = '{3'd1, 3'd7, 3'd1, 3'd7};
    do_reset();
    req_i = 8'h02;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== exp_seq[k]) begin
        errors++; $display("FAIL skip_grant k=%0d got vld=%b idx=%0d exp vld=1 idx=%0d", k, gnt_vld_o, gnt_idx_o, exp_seq[k]);
      end
      req_i = 8'b1000_0010;
      rel_i = 1'b1;
      @(negedge clk);
      rel_i = 1'b0;
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    req_i = 8'h10;
    @(negedge clk);
    checks++; if (gnt_idx_o !== 3'd4 || gnt_vld_o !== 1'b1) begin
      errors++; $display("FAIL drop_first got vld=%b idx=%0d exp vld=1 idx=4", gnt_vld_o, gnt_idx_o);
    end
    req_i = 8'h30;
    @(negedge clk);
    checks++; if (gnt_idx_o !== 3'd4 || gnt_vld_o !== 1'b1) begin
      errors++; $display("FAIL drop_no_preempt got vld=%b idx=%0d exp vld=1 idx=4", gnt_vld_o, gnt_idx_o);
    end
    req_i = 8'h20;
    @(negedge clk);
    checks++; if (gnt_vld_o !== 1'b0 || gnt_o !== 8'h00) begin
      errors++; $display("FAIL drop_gap got vld=%b gnt=%h exp vld=0 gnt=00", gnt_vld_o, gnt_o);
    end
    @(negedge clk);
    checks++; if (gnt_idx_o !== 3'd5 || gnt_o !== 8'h20 || gnt_vld_o !== 1'b1) begin
      errors++; $display("FAIL drop_next got vld=%b idx=%0d gnt=%h exp vld=1 idx=5 gnt=20", gnt_vld_o, gnt_idx_o, gnt_o);
    end
  endtask

  task automatic test_back_to_back();
    // continues from owner 5 granted with ptr at 6
    req_i = 8'h00; rel_i = 1'b1;
    @(negedge clk);
    checks++; if (gnt_vld_o !== 1'b0) begin errors++; $display("FAIL b2b_gap got vld=%b exp=0", gnt_vld_o); end
    @(negedge clk);
    checks++; if (gnt_vld_o !== 1'b0 || gnt_o !== 8'h00) begin
      errors++; $display("FAIL b2b_idle got vld=%b gnt=%h exp vld=0 gnt=00", gnt_vld_o, gnt_o);
    end
    @(negedge clk);
    checks++; if (gnt_vld_o !== 1'b0) begin errors++; $display("FAIL b2b_rel_idle got vld=%b exp=0", gnt_vld_o); end
    req_i = 8'h20; rel_i = 1'b0;
    @(negedge clk);
    checks++; if (gnt_idx_o !== 3'd5 || gnt_vld_o !== 1'b1) begin
      errors++; $display("FAIL b2b_regrant got vld=%b idx=%0d exp vld=1 idx=5", gnt_vld_o, gnt_idx_o);
    end
    rel_i = 1'b1;
    @(negedge clk);
    rel_i = 1'b0;
    @(negedge clk);
    checks++; if (gnt_idx_o !== 3'd5 || gnt_vld_o !== 1'b1) begin
      errors++; $display("FAIL b2b_sole_wrap got vld=%b idx=%0d exp vld=1 idx=5", gnt_vld_o, gnt_idx_o);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    req_i = 8'h03;
`ifdef ARB_TIMEOUT_EN
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 3'd0 || timeout_o !== 1'b0) begin
        errors++; $display("FAIL timeout_hold k=%0d got vld=%b idx=%0d to=%b exp vld=1 idx=0 to=0", k, gnt_vld_o, gnt_idx_o, timeout_o);
      end
    end
    @(negedge clk);
    checks++; if (gnt_vld_o !== 1'b0 || timeout_o !== 1'b1) begin
      errors++; $display("FAIL timeout_pulse got vld=%b to=%b exp vld=0 to=1", gnt_vld_o, timeout_o);
    end
    @(negedge clk);
    checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 3'd1 || timeout_o !== 1'b0) begin
      errors++; $display("FAIL timeout_next got vld=%b idx=%0d to=%b exp vld=1 idx=1 to=0", gnt_vld_o, gnt_idx_o, timeout_o);
    end
`else
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      checks++; if (gnt_vld_o !== 1'b1 || gnt_idx_o !== 3'd0 || timeout_o !== 1'b0) begin
        errors++; $display("FAIL timeout_off_hold k=%0d got vld=%b idx=%0d to=%b exp vld=1 idx=0 to=0", k, gnt_vld_o, gnt_idx_o, timeout_o);
      end
    end
`endif
    req_i = 8'h00;
    @(negedge clk);
  endtask

  task automatic test_async_reset();
    do_reset();
    req_i = 8'h08;
    @(negedge clk);
    checks++; if (gnt_idx_o !== 3'd3 || gnt_vld_o !== 1'b1) begin
      errors++; $display("FAIL areset_pre got vld=%b idx=%0d exp vld=1 idx=3", gnt_vld_o, gnt_idx_o);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (gnt_o !== 8'h00 || gnt_vld_o !== 1'b0) begin
      errors++; $display("FAIL areset_drop got vld=%b gnt=%h exp vld=0 gnt=00", gnt_vld_o, gnt_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    req_i = 8'h28;
    @(negedge clk);
    checks++; if (gnt_idx_o !== 3'd3 || gnt_vld_o !== 1'b1) begin
      errors++; $display("FAIL areset_ptr got vld=%b idx=%0d exp vld=1 idx=3", gnt_vld_o, gnt_idx_o);
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_skip();
    test_owner_drop();
    test_back_to_back();
    test_timeout();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
